// File: rtl/sa_pkg.sv
// ---------------------------------------------------------------------------
// sa_pkg
// Shared definitions for the sa2x2 controller: data width, fixed result
// latency, the job sequencer state type and lane-slice helpers for the packed
// 2-lane activation/result bundles and the 4-lane weight bundle.
// ---------------------------------------------------------------------------
package sa_pkg;

    localparam int DW  = 8;  // weight / activation / partial-sum width
    localparam int LAT = 5;  // activation handshake to res_valid, in cycles

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        STREAM,
        DRAIN,
        DONE
    } state_e;

    // Lane idx of a 2-lane bundle (lane 0 in the LSBs).
    function automatic logic [DW-1:0] lane2(input logic [2*DW-1:0] bus, input int idx);
        return bus[idx*DW +: DW];
    endfunction

    // Lane idx of a 4-lane bundle (lane 0 in the LSBs).
    function automatic logic [DW-1:0] lane4(input logic [4*DW-1:0] bus, input int idx);
        return bus[idx*DW +: DW];
    endfunction

endpackage

// File: rtl/sa_skew_pipe.sv
// ---------------------------------------------------------------------------
// sa_skew_pipe
// Depth-N register delay line carrying a valid bit alongside W bits of data.
// Used for the row-2 activation skew, the column-1 partial-sum hold and the
// result valid/last tracking pipe.
//
// Ports:
//   clk      clock
//   rst_n    asynchronous active-low reset
//   valid_i  valid bit entering stage 0
//   data_i   data entering stage 0
//   valid_o  valid bit leaving stage N-1
//   data_o   data leaving stage N-1
// ---------------------------------------------------------------------------
module sa_skew_pipe #(
    parameter int N = 1,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic [N-1:0] valid_q;
    logic [W-1:0] data_q [N];

    // NOTE: state is updated with non-blocking assignments so every stage
    // samples its predecessor's pre-edge value and the line shifts by exactly
    // one stage per clock, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            // NOTE: the data stages are reset too, not just the valid bits:
            // an abandoned job must not leave stale partial sums that could
            // leak onto the array or the result port after reset.
            for (int i = 0; i < N; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= valid_i;
            data_q[0]  <= data_i;
            for (int i = 1; i < N; i++) begin
                valid_q[i] <= valid_q[i-1];
                data_q[i]  <= data_q[i-1];
            end
        end
    end

    assign valid_o = valid_q[N-1];
    assign data_o  = data_q[N-1];

endmodule

// File: rtl/sa2x2_ctrl.sv
// ---------------------------------------------------------------------------
// sa2x2_ctrl
// Job sequencer and data-alignment stage around the 2x2 weight-stationary
// array. Per job: clear the array, load four weights, stream 2-lane
// activation vectors (row 2 skewed one cycle behind row 1), then de-skew the
// two column sums into one aligned result vector per input vector.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   start, w_in              job start (IDLE only) and {w22,w21,w12,w11}
//   act_valid/ready/data/last activation beat stream, data = {row2,row1}
//   sa_clear, sa_weight_load array control strobes
//   sa_w_11..sa_w_22         stationary weights to the array
//   sa_act_in1/2             skewed activations to the array
//   sa_psum_in1/2            column partial-sum inputs, tied to zero
//   sa_psum_out1/2           column outputs from the array
//   res_valid/data/last      aligned results, data = {col2,col1}
//   busy, done               job in progress / one-cycle completion pulse
// ---------------------------------------------------------------------------
module sa2x2_ctrl
    import sa_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [4*DW-1:0] w_in,
    input  logic            act_valid,
    output logic            act_ready,
    input  logic [2*DW-1:0] act_data,
    input  logic            act_last,
    output logic            sa_clear,
    output logic            sa_weight_load,
    output logic [DW-1:0]   sa_w_11,
    output logic [DW-1:0]   sa_w_12,
    output logic [DW-1:0]   sa_w_21,
    output logic [DW-1:0]   sa_w_22,
    output logic [DW-1:0]   sa_act_in1,
    output logic [DW-1:0]   sa_act_in2,
    output logic [DW-1:0]   sa_psum_in1,
    output logic [DW-1:0]   sa_psum_in2,
    input  logic [DW-1:0]   sa_psum_out1,
    input  logic [DW-1:0]   sa_psum_out2,
    output logic            res_valid,
    output logic [2*DW-1:0] res_data,
    output logic            res_last,
    output logic            busy,
    output logic            done
);

    localparam int              CNT_W      = $clog2(LAT);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(LAT - 1);

    state_e          state_q;
    logic [CNT_W-1:0] drain_cnt_q;
    logic [4*DW-1:0] w_q;
    logic [2*DW-1:0] act_q;
    logic [2*DW-1:0] act_d;
    logic [DW-1:0]   col1_hold;
    logic            act_fire;
    logic            pipe_last;
    logic            unused_row2_vld;
    logic            unused_hold_vld;

    assign act_fire = act_valid & act_ready;
    // Bubbles enter the array as zero activations.
    assign act_d    = act_fire ? act_data : '0;

    // ---------------- Job sequencer (registered outputs) -------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            drain_cnt_q    <= '0;
            w_q            <= '0;
            act_ready      <= 1'b0;
            sa_clear       <= 1'b0;
            sa_weight_load <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            sa_clear       <= 1'b0;
            sa_weight_load <= 1'b0;
            done           <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        w_q      <= w_in;
                        state_q  <= CLEAR;
                        sa_clear <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                CLEAR: begin
                    state_q        <= LOAD;
                    sa_weight_load <= 1'b1;
                end
                LOAD: begin
                    state_q   <= STREAM;
                    act_ready <= 1'b1;
                end
                STREAM: begin
                    if (act_fire && act_last) begin
                        state_q     <= DRAIN;
                        act_ready   <= 1'b0;
                        drain_cnt_q <= '0;
                    end
                end
                DRAIN: begin
                    // The last beat's result is on the port in the final
                    // counted cycle, so leaving here implies res_last was seen.
                    if (drain_cnt_q == DRAIN_LAST) begin
                        state_q <= DONE;
                        done    <= 1'b1;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sa_w_11     = lane4(w_q, 0);
    assign sa_w_12     = lane4(w_q, 1);
    assign sa_w_21     = lane4(w_q, 2);
    assign sa_w_22     = lane4(w_q, 3);
    assign sa_psum_in1 = '0;
    assign sa_psum_in2 = '0;

    // ---------------- Feed and capture registers --------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            act_q    <= '0;
            res_data <= '0;
        end else begin
            act_q    <= act_d;
            res_data <= {sa_psum_out2, col1_hold};
        end
    end

    assign sa_act_in1 = lane2(act_q, 0);

    // Row 2 trails row 1 by one register. Bubbles already travel as zero
    // data, so the valid bit of this instance carries no information.
    sa_skew_pipe #(.N(1), .W(DW)) u_row2_skew (
        .clk     (clk),
        .rst_n   (rst),
        .valid_i (1'b1),
        .data_i  (lane2(act_q, 1)),
        .valid_o (unused_row2_vld),
        .data_o  (sa_act_in2)
    );

    // Column 1 finishes a cycle before column 2; hold it so both columns of
    // one input vector are registered into res_data together.
    sa_skew_pipe #(.N(1), .W(DW)) u_col1_hold (
        .clk     (clk),
        .rst_n   (rst),
        .valid_i (1'b1),
        .data_i  (sa_psum_out1),
        .valid_o (unused_hold_vld),
        .data_o  (col1_hold)
    );

    // Tracks each accepted beat (and its last flag) to the result port.
    sa_skew_pipe #(.N(LAT), .W(1)) u_vld_pipe (
        .clk     (clk),
        .rst_n   (rst),
        .valid_i (act_fire),
        .data_i  (act_fire & act_last),
        .valid_o (res_valid),
        .data_o  (pipe_last)
    );

    assign res_last = res_valid & pipe_last;

endmodule

// File: tb/tb_sa2x2_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sa2x2_ctrl
// Self-checking bench for sa2x2_ctrl. Contains a behavioural 2x2
// weight-stationary array as the environment, a result scoreboard computed
// from the matrix-vector formula, a table of single-beat jobs with
// hand-derived results, hand-written multi-cycle sequences and random jobs.
// ---------------------------------------------------------------------------
module tb_sa2x2_ctrl;
    import sa_pkg::*;

    logic            clk;
    logic            rst;
    logic            start;
    logic [4*DW-1:0] w_in;
    logic            act_valid;
    logic            act_ready;
    logic [2*DW-1:0] act_data;
    logic            act_last;
    logic            sa_clear;
    logic            sa_weight_load;
    logic [DW-1:0]   sa_w_11, sa_w_12, sa_w_21, sa_w_22;
    logic [DW-1:0]   sa_act_in1, sa_act_in2;
    logic [DW-1:0]   sa_psum_in1, sa_psum_in2;
    logic [DW-1:0]   sa_psum_out1, sa_psum_out2;
    logic            res_valid;
    logic [2*DW-1:0] res_data;
    logic            res_last;
    logic            busy;
    logic            done;

    sa2x2_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .w_in           (w_in),
        .act_valid      (act_valid),
        .act_ready      (act_ready),
        .act_data       (act_data),
        .act_last       (act_last),
        .sa_clear       (sa_clear),
        .sa_weight_load (sa_weight_load),
        .sa_w_11        (sa_w_11),
        .sa_w_12        (sa_w_12),
        .sa_w_21        (sa_w_21),
        .sa_w_22        (sa_w_22),
        .sa_act_in1     (sa_act_in1),
        .sa_act_in2     (sa_act_in2),
        .sa_psum_in1    (sa_psum_in1),
        .sa_psum_in2    (sa_psum_in2),
        .sa_psum_out1   (sa_psum_out1),
        .sa_psum_out2   (sa_psum_out2),
        .res_valid      (res_valid),
        .res_data       (res_data),
        .res_last       (res_last),
        .busy           (busy),
        .done           (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- Behavioural weight-stationary array ------------------
    // PE(r,c): weight w_rc, activations flow right, partial sums flow down.
    logic [DW-1:0] m_w11, m_w12, m_w21, m_w22;
    logic [DW-1:0] p11, p21, p12, p22, a11, a21;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_w11 <= '0; m_w12 <= '0; m_w21 <= '0; m_w22 <= '0;
            p11 <= '0; p21 <= '0; p12 <= '0; p22 <= '0; a11 <= '0; a21 <= '0;
        end else if (sa_clear) begin
            p11 <= '0; p21 <= '0; p12 <= '0; p22 <= '0; a11 <= '0; a21 <= '0;
        end else begin
            if (sa_weight_load) begin
                m_w11 <= sa_w_11; m_w12 <= sa_w_12; m_w21 <= sa_w_21; m_w22 <= sa_w_22;
            end
            p11 <= sa_psum_in1 + sa_act_in1 * m_w11;
            a11 <= sa_act_in1;
            p21 <= p11 + sa_act_in2 * m_w21;
            a21 <= sa_act_in2;
            p12 <= sa_psum_in2 + a11 * m_w12;
            p22 <= p12 + a21 * m_w22;
        end
    end

    assign sa_psum_out1 = p21;
    assign sa_psum_out2 = p22;

    // ---------------- Reference model and bookkeeping ----------------------
    function automatic logic [15:0] model(input logic [31:0] w, input logic [15:0] a);
        int unsigned c1, c2;
        c1 = 32'(a[7:0]) * 32'(w[7:0])  + 32'(a[15:8]) * 32'(w[23:16]);
        c2 = 32'(a[7:0]) * 32'(w[15:8]) + 32'(a[15:8]) * 32'(w[31:24]);
        return {8'(c2 % 256), 8'(c1 % 256)};
    endfunction

    typedef struct {
        logic [15:0] data;
        logic        last;
        int          cyc;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] w;
        logic [15:0] act;
        logic [15:0] exp;
    } vec_t;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          last_hs_cyc = 0;
    logic [31:0] job_w    = '0;
    logic [15:0] last_res = '0;
    exp_t        exp_q[$];
    logic [15:0] got_q[$];
    logic        gotlast_q[$];
    int          gotcyc_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, got, want, cyc);
    endtask

    // Handshakes become expected results computed from the job's weights.
    always @(posedge clk) begin
        if (!rst) begin
            exp_q.delete();
        end else if (act_valid && act_ready) begin
            exp_q.push_back('{data: model(job_w, act_data), last: act_last, cyc: cyc});
            if (act_last) last_hs_cyc <= cyc;
        end
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (rst && res_valid) begin
            check("res_expected_pending", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("res_data", res_data, e.data);
                check("res_last", res_last, e.last);
                check("res_latency", cyc - e.cyc, LAT);
            end
            got_q.push_back(res_data);
            gotlast_q.push_back(res_last);
            gotcyc_q.push_back(cyc);
            last_res = res_data;
        end
    end

    // ---------------- Stimulus tasks ---------------------------------------
    task automatic clear_got();
        got_q.delete();
        gotlast_q.delete();
        gotcyc_q.delete();
    endtask

    task automatic start_job(input logic [31:0] w);
        @(negedge clk);
        start = 1'b1;
        w_in  = w;
        job_w = w;
        @(negedge clk);
        start = 1'b0;
        w_in  = $urandom();
        check("clear_strobe", sa_clear, 1);
        check("no_load_in_clear", sa_weight_load, 0);
        check("busy_in_clear", busy, 1);
        check("not_ready_in_clear", act_ready, 0);
        @(negedge clk);
        check("clear_one_cycle", sa_clear, 0);
        check("load_strobe", sa_weight_load, 1);
        check("weights_in_load", {sa_w_22, sa_w_21, sa_w_12, sa_w_11}, w);
        @(negedge clk);
        check("load_one_cycle", sa_weight_load, 0);
        check("ready_in_stream", act_ready, 1);
    endtask

    task automatic send_beat(input logic [15:0] a, input logic last, input int gap);
        for (int g = 0; g < gap; g++) begin
            act_valid = 1'b0;
            act_data  = 16'($urandom());
            act_last  = 1'($urandom());
            @(negedge clk);
        end
        act_valid = 1'b1;
        act_data  = a;
        act_last  = last;
        @(negedge clk);
        act_valid = 1'b0;
        act_last  = 1'b0;
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("done_seen", 32'(seen), 1);
        if (seen) begin
            check("done_latency", cyc - last_hs_cyc, LAT + 1);
            check("busy_in_done", busy, 1);
            check("results_drained", exp_q.size(), 0);
            @(negedge clk);
            check("done_one_cycle", done, 0);
            check("busy_low_idle", busy, 0);
        end
    endtask

    // Three beats {a2,a1} = {1,1}, {0,2}, {0,3} with weights 1,2,3,4 and an
    // optional bubble gap before beat 2.
    task automatic run_seq3(input int gap);
        clear_got();
        start_job(32'h04030201);
        send_beat(16'h0101, 1'b0, 0);
        send_beat(16'h0002, 1'b0, gap);
        send_beat(16'h0003, 1'b1, 0);
        wait_done();
        check("seq3_count", got_q.size(), 3);
        if (got_q.size() == 3) begin
            check("seq3_r0", got_q[0], 16'h0604);
            check("seq3_r1", got_q[1], 16'h0402);
            check("seq3_r2", got_q[2], 16'h0603);
            check("seq3_last_flags", {gotlast_q[0], gotlast_q[1], gotlast_q[2]}, 3'b001);
            check("seq3_gap01", gotcyc_q[1] - gotcyc_q[0], 1 + gap);
            check("seq3_gap12", gotcyc_q[2] - gotcyc_q[1], 1);
        end
    endtask

    // ---------------- Test sequence ----------------------------------------
    vec_t vecs[5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{name: "vec_basic",  w: 32'h04030201, act: 16'h0605, exp: 16'h2217};
        vecs[1] = '{name: "vec_wrap",   w: 32'h05100310, act: 16'h0808, exp: 16'h4000};
        vecs[2] = '{name: "vec_max",    w: 32'hFFFFFFFF, act: 16'hFFFF, exp: 16'h0202};
        vecs[3] = '{name: "vec_diag",   w: 32'h09000007, act: 16'h0403, exp: 16'h2415};
        vecs[4] = '{name: "vec_cross",  w: 32'h00010100, act: 16'h3412, exp: 16'h1234};

        rst       = 1'b1;
        start     = 1'b0;
        w_in      = '0;
        act_valid = 1'b0;
        act_data  = '0;
        act_last  = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("rst_act_ready", act_ready, 0);
        check("rst_busy_done", {busy, done}, 0);
        check("rst_sa_ctrl", {sa_clear, sa_weight_load}, 0);
        check("rst_res", {res_valid, res_last, res_data}, 0);
        check("rst_sa_w", {sa_w_22, sa_w_21, sa_w_12, sa_w_11}, 0);
        check("rst_sa_act", {sa_act_in2, sa_act_in1, sa_psum_in2, sa_psum_in1}, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("idle_busy", busy, 0);

        // Table of single-beat jobs with hand-derived results.
        for (int i = 0; i < 5; i++) begin
            clear_got();
            start_job(vecs[i].w);
            send_beat(vecs[i].act, 1'b1, 0);
            wait_done();
            check({vecs[i].name, "_count"}, got_q.size(), 1);
            check(vecs[i].name, last_res, vecs[i].exp);
        end

        // Back-to-back and bubbled streams.
        run_seq3(0);
        run_seq3(2);

        // start during STREAM with different weights is ignored.
        clear_got();
        start_job(32'h04030201);
        send_beat(16'h0101, 1'b0, 0);
        start = 1'b1;
        w_in  = 32'hDEADBEEF;
        send_beat(16'h0002, 1'b0, 0);
        send_beat(16'h0003, 1'b1, 0);
        start = 1'b0;
        check("weights_kept", {sa_w_22, sa_w_21, sa_w_12, sa_w_11}, 32'h04030201);
        wait_done();
        check("ignored_start_r2", last_res, 16'h0603);

        // Reset in the middle of STREAM after two accepted beats.
        clear_got();
        start_job(32'h04030201);
        send_beat(16'h0705, 1'b0, 0);
        send_beat(16'h0906, 1'b0, 0);
        #2 rst = 1'b0;
        #1;
        check("midrst_act_ready", act_ready, 0);
        check("midrst_busy", busy, 0);
        check("midrst_sa_act", {sa_act_in2, sa_act_in1}, 0);
        check("midrst_sa_w", {sa_w_22, sa_w_21, sa_w_12, sa_w_11}, 0);
        check("midrst_other", {sa_clear, sa_weight_load, res_valid, res_last, res_data, done}, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        begin
            int n_vld, n_done;
            n_vld  = 0;
            n_done = 0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (res_valid) n_vld++;
                if (done) n_done++;
            end
            check("midrst_no_res", n_vld, 0);
            check("midrst_no_done", n_done, 0);
            check("midrst_idle", busy, 0);
        end
        clear_got();
        start_job(32'h04030201);
        send_beat(16'h0605, 1'b1, 0);
        wait_done();
        check("post_rst_job", last_res, 16'h2217);

        // Random jobs against the scoreboard.
        for (int j = 0; j < 15; j++) begin
            int nb;
            clear_got();
            nb = int'($urandom_range(1, 6));
            start_job($urandom());
            for (int b = 0; b < nb; b++) begin
                send_beat(16'($urandom()), 1'(b == nb - 1), int'($urandom_range(0, 2)));
            end
            wait_done();
            check("rand_count", got_q.size(), nb);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
